vga_timing_gen: RTL and testbench

//  Raster timing source for 640x480@60 Hz VGA on the 25 MHz pixel clock. Drives the
//  i_hcounter/i_vcounter buses consumed by the emoji frame generators and takes back

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_timing_gen_if.sv | 23 ++
 rtl/vga_delay_line.sv | 39 +++
 rtl/vga_timing_gen.sv | 97 +++++++++
 tb/tb_vga_timing_gen.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, color words and the sync/active bundle
// used by the timing generator and the frame generators that consume its counters.
package vga_timing_pkg;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;

    localparam int H_TOTAL = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
    localparam int V_TOTAL = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;

    localparam int CNT_W   = 10;
    localparam int COLOR_W = 12;

    localparam logic [COLOR_W-1:0] COLOR_BLACK  = 12'h000;
    localparam logic [COLOR_W-1:0] COLOR_WHITE  = 12'hFFF;
    localparam logic [COLOR_W-1:0] COLOR_RED    = 12'hF00;
    localparam logic [COLOR_W-1:0] COLOR_GREEN  = 12'h0F0;
    localparam logic [COLOR_W-1:0] COLOR_BLUE   = 12'h00F;
    localparam logic [COLOR_W-1:0] COLOR_YELLOW = 12'hFF0;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_bits_t;

    // Sync pins idle high, video blanked.
    localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

    function automatic logic in_span(input logic [10:0] val,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Counter/color bus between the timing generator (master) and a frame generator (slave).
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic [CNT_W-1:0]   o_hcounter;
    logic [CNT_W-1:0]   o_vcounter;
    logic               o_frame_start;
    logic [COLOR_W-1:0] i_color_data;

    modport master (
        output o_hcounter,
        output o_vcounter,
        output o_frame_start,
        input  i_color_data
    );

    modport slave (
        input  o_hcounter,
        input  o_vcounter,
        input  o_frame_start,
        output i_color_data
    );
endinterface

// File: rtl/vga_delay_line.sv
// Resettable shift register of DEPTH stages; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] prev;
                logic [WIDTH-1:0] q_reg;

                if (gi == 0) begin : g_first
                    assign prev = d;
                end else begin : g_next
                    assign prev = g_stage[gi-1].q_reg;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= RESET_VAL;
                    end else begin
                        q_reg <= prev;
                    end
                end
            end
            assign q = g_stage[DEPTH-1].q_reg;
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/active decode and pin register for VGA output; sync and
// active are delayed to line up with the color word returned by the frame generator.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int PIPE_DLY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master bus,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic [3:0]       o_red,
    output logic [3:0]       o_green,
    output logic [3:0]       o_blue
);

    localparam logic [10:0] H_LAST   = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [10:0] V_LAST   = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_LO = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_HI = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_ACT_LO = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_HI = 11'(V_SYNC + V_BP + V_ACTIVE);

    logic [CNT_W-1:0] h_cnt_reg;
    logic [CNT_W-1:0] v_cnt_reg;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;
    sync_bits_t       stage0;
    sync_bits_t       stage_d;

    assign h_ext = {1'b0, h_cnt_reg};
    assign v_ext = {1'b0, v_cnt_reg};

    // Vertical count advances on the same edge the horizontal count wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_ext == H_LAST) begin
            h_cnt_reg <= '0;
            if (v_ext == V_LAST) begin
                v_cnt_reg <= '0;
            end else begin
                v_cnt_reg <= v_cnt_reg + 10'd1;
            end
        end else begin
            h_cnt_reg <= h_cnt_reg + 10'd1;
        end
    end

    assign bus.o_hcounter    = h_cnt_reg;
    assign bus.o_vcounter    = v_cnt_reg;
    // Gated so the pulse stays low while held in reset with counters at zero.
    assign bus.o_frame_start = rst_n && (h_cnt_reg == '0) && (v_cnt_reg == '0);

    always_comb begin
        stage0     = SYNC_IDLE;
        stage0.hs  = (h_ext >= H_SYNC_W);
        stage0.vs  = (v_ext >= V_SYNC_W);
        stage0.act = in_span(h_ext, H_ACT_LO, H_ACT_HI) && in_span(v_ext, V_ACT_LO, V_ACT_HI);
    end

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (stage0),
        .q     (stage_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hsync <= 1'b1;
            o_vsync <= 1'b1;
            {o_red, o_green, o_blue} <= COLOR_BLACK;
        end else begin
            o_hsync <= stage_d.hs;
            o_vsync <= stage_d.vs;
            {o_red, o_green, o_blue} <= stage_d.act ? bus.i_color_data : COLOR_BLACK;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size PIPE_DLY=1 instance and a shrunken PIPE_DLY=3 instance.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int PA  = 1;
    localparam int PB  = 3;
    localparam int BHS = 8, BHB = 4, BHA = 16, BHF = 4;
    localparam int BVS = 2, BVB = 3, BVA = 6, BVF = 2;
    localparam int BHT = 32, BVT = 13;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } pins_t;

    typedef struct {
        int          v;
        int          h;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    localparam pins_t IDLE = {1'b1, 1'b1, 12'h000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    vga_timing_gen_if bus_a ();
    vga_timing_gen_if bus_b ();

    logic       hs_a, vs_a, hs_b, vs_b;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

    vga_timing_gen #(.PIPE_DLY(PA)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_a),
        .o_hsync (hs_a),
        .o_vsync (vs_a),
        .o_red   (r_a),
        .o_green (g_a),
        .o_blue  (b_a)
    );

    vga_timing_gen #(
        .H_SYNC(BHS), .H_BP(BHB), .H_ACTIVE(BHA), .H_FP(BHF),
        .V_SYNC(BVS), .V_BP(BVB), .V_ACTIVE(BVA), .V_FP(BVF),
        .PIPE_DLY(PB)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_b),
        .o_hsync (hs_b),
        .o_vsync (vs_b),
        .o_red   (r_b),
        .o_green (g_b),
        .o_blue  (b_b)
    );

    // Frame generator models: A registers once, B has a three-register pipeline.
    logic [11:0] gb1, gb2;
    always @(posedge clk) begin
        bus_a.i_color_data <= (bus_a.o_hcounter == 10'd144) ? 12'hF00 : 12'h0F0;
        gb1 <= {bus_b.o_hcounter[3:0], bus_b.o_vcounter[3:0], 4'h5};
        gb2 <= gb1;
        bus_b.i_color_data <= gb2;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected pins for raster position k cycles after release, plus the counter values.
    function automatic pins_t model(input int k, input bit is_b, output int h, output int v);
        int ht, vt, hsw, vsw, hlo, hhi, vlo, vhi;
        pins_t p;
        if (is_b) begin
            ht = BHT; vt = BVT; hsw = BHS; vsw = BVS;
            hlo = BHS + BHB; hhi = hlo + BHA; vlo = BVS + BVB; vhi = vlo + BVA;
        end else begin
            ht = 800; vt = 525; hsw = 96; vsw = 2;
            hlo = 144; hhi = 784; vlo = 35; vhi = 515;
        end
        h = k % ht;
        v = (k / ht) % vt;
        p.hs = (h >= hsw);
        p.vs = (v >= vsw);
        p.rgb = 12'h000;
        if (h >= hlo && h < hhi && v >= vlo && v < vhi) begin
            if (is_b) p.rgb = {h[3:0], v[3:0], 4'h5};
            else      p.rgb = (h == 144) ? 12'hF00 : 12'h0F0;
        end
        return p;
    endfunction

    // Scoreboard: one expectation pushed per cycle, popped PIPE_DLY+1 cycles later.
    pins_t qa[$];
    pins_t qb[$];
    bit    sb_on = 1'b0;
    int    sb_k = 0;
    int    sb_fail = 0;

    always @(negedge clk) begin
        int    h, v;
        pins_t e, got;
        if (sb_on && sb_fail < 20) begin
            sb_k++;
            qa.push_back(model(sb_k, 1'b0, h, v));
            e = qa.pop_front();
            got = {hs_a, vs_a, r_a, g_a, b_a};
            checks++;
            if (got !== e) begin
                failures++; sb_fail++;
                $display("FAIL sb_pins_a k=%0d actual=%h required=%h", sb_k, got, e);
            end
            checks++;
            if (int'(bus_a.o_hcounter) != h || int'(bus_a.o_vcounter) != v) begin
                failures++; sb_fail++;
                $display("FAIL sb_cnt_a k=%0d actual=%0d,%0d required=%0d,%0d",
                         sb_k, bus_a.o_hcounter, bus_a.o_vcounter, h, v);
            end
            qb.push_back(model(sb_k, 1'b1, h, v));
            e = qb.pop_front();
            got = {hs_b, vs_b, r_b, g_b, b_b};
            checks++;
            if (got !== e) begin
                failures++; sb_fail++;
                $display("FAIL sb_pins_b k=%0d actual=%h required=%h", sb_k, got, e);
            end
            checks++;
            if (int'(bus_b.o_hcounter) != h || int'(bus_b.o_vcounter) != v) begin
                failures++; sb_fail++;
                $display("FAIL sb_cnt_b k=%0d actual=%0d,%0d required=%0d,%0d",
                         sb_k, bus_b.o_hcounter, bus_b.o_vcounter, h, v);
            end
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return !hs_a;
            1:       return !hs_b;
            2:       return !vs_b;
            default: return bus_b.o_frame_start;
        endcase
    endfunction

    // Sample counts (from call) of first assertion, following deassertion, next assertion.
    task automatic edge_times(input int which, input int limit,
                              output int t1, output int t2, output int t3);
        int   t = 0;
        logic prev = 1'b0;
        logic cur;
        t1 = -1; t2 = -1; t3 = -1;
        while (t < limit && t3 < 0) begin
            @(posedge clk); #1; t++;
            cur = sig(which);
            if (cur && !prev) begin
                if (t1 < 0) t1 = t;
                else        t3 = t;
            end
            if (!cur && prev && t1 >= 0 && t2 < 0) t2 = t;
            prev = cur;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hcnt_a"}, 32'(bus_a.o_hcounter), 0);
        check({tag, "_vcnt_a"}, 32'(bus_a.o_vcounter), 0);
        check({tag, "_pins_a"}, 32'({hs_a, vs_a, r_a, g_a, b_a}), 32'(IDLE));
        check({tag, "_fs_a"},   32'(bus_a.o_frame_start), 0);
        check({tag, "_vcnt_b"}, 32'(bus_b.o_vcounter), 0);
        check({tag, "_pins_b"}, 32'({hs_b, vs_b, r_b, g_b, b_b}), 32'(IDLE));
        $display("reset %s hs_a=%b vs_a=%b hs_b=%b vs_b=%b", tag, hs_a, vs_a, hs_b, vs_b);
    endtask

    bit go = 1'b0;
    bit tdone = 1'b0;

    // Sync widths/periods and the frame wrap, measured from the final release.
    initial begin
        int a1, a2, a3, h1, h2, h3, v1, v2, v3, f1, f2, f3;
        bit found;
        wait (go);
        fork
            edge_times(0, 2000, a1, a2, a3);
            edge_times(1, 200,  h1, h2, h3);
            edge_times(2, 1000, v1, v2, v3);
        join
        check("hsync_a_first", 32'(a1), PA + 1);
        check("hsync_a_width", 32'(a2 - a1), 96);
        check("hsync_a_period", 32'(a3 - a1), 800);
        $display("line A first=%0d width=%0d period=%0d", a1, a2 - a1, a3 - a1);
        check("hsync_b_first", 32'(h1), PB + 1);
        check("hsync_b_width", 32'(h2 - h1), BHS);
        check("hsync_b_period", 32'(h3 - h1), BHT);
        $display("line B first=%0d width=%0d period=%0d", h1, h2 - h1, h3 - h1);
        check("vsync_b_first", 32'(v1), PB + 1);
        check("vsync_b_width", 32'(v2 - v1), BVS * BHT);
        check("vsync_b_period", 32'(v3 - v1), BHT * BVT);
        $display("frame B vsync first=%0d width=%0d period=%0d", v1, v2 - v1, v3 - v1);
        edge_times(3, 1000, f1, f2, f3);
        check("fstart_b_width", 32'(f2 - f1), 1);
        check("fstart_b_period", 32'(f3 - f1), BHT * BVT);
        $display("frame B start width=%0d period=%0d", f2 - f1, f3 - f1);
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(posedge clk); #1;
            if (bus_b.o_hcounter == 10'(BHT - 1) && bus_b.o_vcounter == 10'(BVT - 1)) found = 1'b1;
        end
        check("wrap_b_found", 32'(found), 1);
        @(posedge clk); #1;
        check("wrap_b_cnt", 32'({bus_b.o_hcounter, bus_b.o_vcounter}), 0);
        check("wrap_b_fs_on", 32'(bus_b.o_frame_start), 1);
        @(posedge clk); #1;
        check("wrap_b_fs_off", 32'(bus_b.o_frame_start), 0);
        $display("wrap B h=%0d v=%0d", bus_b.o_hcounter, bus_b.o_vcounter);
        tdone = 1'b1;
    end

    vec_t vecs[13];

    initial begin
        bit found;
        int h0, v0;
        vecs[0]  = '{0,   0,   1'b0, 1'b0, 12'h000};
        vecs[1]  = '{0,   95,  1'b0, 1'b0, 12'h000};
        vecs[2]  = '{0,   96,  1'b1, 1'b0, 12'h000};
        vecs[3]  = '{1,   500, 1'b1, 1'b0, 12'h000};
        vecs[4]  = '{2,   10,  1'b0, 1'b1, 12'h000};
        vecs[5]  = '{2,   100, 1'b1, 1'b1, 12'h000};
        vecs[6]  = '{34,  144, 1'b1, 1'b1, 12'h000};
        vecs[7]  = '{35,  143, 1'b1, 1'b1, 12'h000};
        vecs[8]  = '{35,  144, 1'b1, 1'b1, 12'hF00};
        vecs[9]  = '{35,  145, 1'b1, 1'b1, 12'h0F0};
        vecs[10] = '{35,  783, 1'b1, 1'b1, 12'h0F0};
        vecs[11] = '{35,  784, 1'b1, 1'b1, 12'h000};
        vecs[12] = '{36,  144, 1'b1, 1'b1, 12'hF00};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset("initial");
        @(negedge clk); #2 rst_n = 1'b1;
        // Land mid-line inside A's hsync pulse and B's visible window.
        repeat (2420) @(posedge clk);
        #5 rst_n = 1'b0;
        #1 check_reset("midline");
        repeat (3) @(posedge clk);
        #1 check_reset("held");

        @(negedge clk); #2 rst_n = 1'b1;
        qa.delete(); qb.delete();
        for (int i = 0; i < PA; i++) qa.push_back(IDLE);
        for (int i = 0; i < PB; i++) qb.push_back(IDLE);
        qa.push_back(model(0, 1'b0, h0, v0));
        qb.push_back(model(0, 1'b1, h0, v0));
        sb_on = 1'b1;
        go = 1'b1;

        // Pins at counter (h+2, v) reflect raster position (h, v) for PIPE_DLY=1.
        for (int i = 0; i < 13; i++) begin
            found = 1'b0;
            for (int n = 0; n < 40000 && !found; n++) begin
                @(posedge clk); #1;
                if (int'(bus_a.o_hcounter) == vecs[i].h + 2 && int'(bus_a.o_vcounter) == vecs[i].v)
                    found = 1'b1;
            end
            check($sformatf("vec%0d_found", i), 32'(found), 1);
            check($sformatf("vec%0d_hsync", i), 32'(hs_a), 32'(vecs[i].hs));
            check($sformatf("vec%0d_vsync", i), 32'(vs_a), 32'(vecs[i].vs));
            check($sformatf("vec%0d_rgb", i), 32'({r_a, g_a, b_a}), 32'(vecs[i].rgb));
            $display("vec %0d v=%0d h=%0d hs=%b vs=%b rgb=%h", i, vecs[i].v, vecs[i].h,
                     hs_a, vs_a, {r_a, g_a, b_a});
        end

        for (int n = 0; n < 5000 && !tdone; n++) @(posedge clk);
        check("timing_done", 32'(tdone), 1);
        sb_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
